serial_reed_solomon_encoder: RTL and testbench

Symbol-serial systematic Reed-Solomon encoder over GF(2^8), the transmit-side counterpart of the decoder's syndrome/Berlekamp-Massey path. It accepts a stream of message symbols and forwards each one unchanged. In parallel it runs a generator-polynomial LFSR. After the last message symbol it emits the parity symbols, highest-order first. Generator coefficients and field reduction matrix are programmed by the integrator. The reduction matrix uses the same format as the decoder, so one register set serves both blocks.

---
 rtl/serial_reed_solomon_encoder.sv | 217 +++++++++++++++++++++
 tb/tb_serial_reed_solomon_encoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_reed_solomon_encoder.sv
// -----------------------------------------------------------------------------
// serial_reed_solomon_encoder
//   Symbol-serial systematic Reed-Solomon encoder over GF(2^8). Message symbols
//   are forwarded unchanged through a one-deep output register while a
//   generator-polynomial LFSR accumulates parity. After the last message symbol
//   the P parity symbols are emitted, highest-order first.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   reduction_matrix  [55:0] seven 8-bit rows, row i = x^(8+i) mod p(x);
//                     [56] reduction enable (set for a real field)
//   parity_count      P, number of parity symbols (clamped to 2*MAX_ERRORS)
//   gen_poly_flat     g_0..g_{P-1}, g_k at [8k+7:8k], monic term implicit
//   in_data/valid/last/ready    message symbol stream in
//   out_data/valid/last/ready   codeword symbol stream out
//   busy              first accepted message symbol .. final symbol accepted
//
// Optional feature macro: RS_ENC_PARAM_LATCH_EN
//   defined   -> parity_count/gen_poly_flat captured at the first symbol of
//                each codeword
//   undefined -> both used live, held stable by the integrator
// -----------------------------------------------------------------------------

module finite_field_multiplier_mastravito (
    input  logic [56:0] reduction_matrix_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [7:0]  p_o
);
    logic [14:0] d;

    // Carry-less product, then fold bits x^8..x^14 back through the matrix rows.
    always_comb begin
        d = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            for (int unsigned j = 0; j < 8; j++) begin
                d[i+j] = d[i+j] ^ (a_i[i] & b_i[j]);
            end
        end
        p_o = d[7:0];
        if (reduction_matrix_i[56]) begin
            for (int unsigned i = 0; i < 7; i++) begin
                if (d[8+i]) p_o = p_o ^ reduction_matrix_i[8*i +: 8];
            end
        end
    end
endmodule

module serial_reed_solomon_encoder #(
    parameter int unsigned MAX_ERRORS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [56:0]                   reduction_matrix,
    input  logic [$clog2(2*MAX_ERRORS):0] parity_count,
    input  logic [16*MAX_ERRORS-1:0]      gen_poly_flat,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic                          busy
);
    localparam int unsigned NP = 2 * MAX_ERRORS;
    localparam int unsigned CW = $clog2(NP) + 1;

    localparam logic [0:0] ST_DATA   = 1'b0;
    localparam logic [0:0] ST_PARITY = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NP-1:0][7:0]   r_q, r_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;

    logic [CW-1:0]        pc_eff;
    logic [8*NP-1:0]      gen_eff;
    logic [CW-1:0]        p_sel;
    logic [NP-1:0]        act;
    logic [7:0]           top;
    logic [7:0]           fb;
    logic [NP-1:0][7:0]   prod;
    logic                 out_free;
    logic                 accept;

    assign out_free = !valid_q || out_ready;
    assign in_ready = (state_q == ST_DATA) && out_free;
    assign accept   = in_valid && in_ready;

`ifdef RS_ENC_PARAM_LATCH_EN
    logic [CW-1:0]   pc_q;
    logic [8*NP-1:0] gen_q;
    logic            sop_q;
    logic            use_live;

    // The first symbol of a codeword must already see the new parameters,
    // so the live inputs are used in that cycle and the capture afterwards.
    assign use_live = (state_q == ST_DATA) && sop_q;
    assign pc_eff   = use_live ? parity_count  : pc_q;
    assign gen_eff  = use_live ? gen_poly_flat : gen_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= '0;
            gen_q <= '0;
            sop_q <= 1'b1;
        end else if (accept) begin
            sop_q <= in_last;
            if (sop_q) begin
                pc_q  <= parity_count;
                gen_q <= gen_poly_flat;
            end
        end
    end
`else
    assign pc_eff  = parity_count;
    assign gen_eff = gen_poly_flat;
`endif

    assign p_sel = (pc_eff > CW'(NP)) ? CW'(NP) : pc_eff;

    // Registers at or above P are held at zero so a later, longer codeword
    // never inherits stale contents.
    always_comb begin
        top = '0;
        for (int unsigned k = 0; k < NP; k++) begin
            act[k] = (CW'(k) < p_sel);
            if (CW'(k + 1) == p_sel) top = r_q[k];
        end
    end

    assign fb = in_data ^ top;

    for (genvar g = 0; g < NP; g++) begin : g_mul
        finite_field_multiplier_mastravito u_mul (
            .reduction_matrix_i (reduction_matrix),
            .a_i                (fb),
            .b_i                (gen_eff[8*g +: 8]),
            .p_o                (prod[g])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (last_q) busy_d = 1'b0;
        end

        if (accept) begin
            r_d[0] = act[0] ? prod[0] : '0;
            for (int unsigned k = 1; k < NP; k++) begin
                r_d[k] = act[k] ? (r_q[k-1] ^ prod[k]) : '0;
            end
            data_d  = in_data;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            last_d  = 1'b0;
            if (in_last) begin
                if (p_sel == '0) begin
                    last_d = 1'b1;
                end else begin
                    state_d = ST_PARITY;
                    cnt_d   = p_sel;
                end
            end
        end else if ((state_q == ST_PARITY) && out_free) begin
            r_d[0] = '0;
            for (int unsigned k = 1; k < NP; k++) begin
                r_d[k] = act[k] ? r_q[k-1] : '0;
            end
            data_d  = top;
            valid_d = 1'b1;
            cnt_d   = cnt_q - 1'b1;
            last_d  = (cnt_q == CW'(1));
            if (cnt_q == CW'(1)) state_d = ST_DATA;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
            r_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_serial_reed_solomon_encoder.sv
module tb_serial_reed_solomon_encoder;
    logic         clk = 1'b0;
    logic         rst;
    logic [56:0]  reduction_matrix;
    logic [5:0]   parity_count;
    logic [255:0] gen_poly_flat;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] msg_q[$];
    logic [8:0] exp_q[$];   // {last, data}

    always #5 clk = ~clk;

    serial_reed_solomon_encoder #(.MAX_ERRORS(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .reduction_matrix (reduction_matrix),
        .parity_count     (parity_count),
        .gen_poly_flat    (gen_poly_flat),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_last         (out_last),
        .out_ready        (out_ready),
        .busy             (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // GF(2^8) multiply, field polynomial 0x11D, shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y, p;
        x = a; y = b; p = '0;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            y = y >> 1;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [56:0] make_matrix();
        logic [56:0] m;
        logic [7:0]  v;
        m = '0;
        v = 8'h01;
        for (int n = 1; n <= 14; n++) begin
            v = v[7] ? ({v[6:0], 1'b0} ^ 8'h1D) : {v[6:0], 1'b0};
            if (n >= 8) m[8*(n-8) +: 8] = v;
        end
        m[56] = 1'b1;
        return m;
    endfunction

    // g_0/g_1 given, every higher coefficient random junk.
    function automatic logic [255:0] gen_with(input logic [7:0] g0, input logic [7:0] g1);
        logic [255:0] g;
        for (int i = 0; i < 8; i++) g[32*i +: 32] = $urandom;
        g[7:0]  = g0;
        g[15:8] = g1;
        return g;
    endfunction

    // Codeword = message followed by remainder of m(x)*x^P divided by g(x).
    task automatic build_expected(input int unsigned pc, input logic [255:0] gen);
        int unsigned pe, k;
        logic [7:0]  c[$];
        logic [7:0]  coef;
        pe = (pc > 32) ? 32 : pc;
        k  = msg_q.size();
        c  = {};
        foreach (msg_q[i]) c.push_back(msg_q[i]);
        for (int unsigned j = 0; j < pe; j++) c.push_back(8'h00);
        for (int unsigned i = 0; i < k; i++) begin
            coef = c[i];
            for (int unsigned j = 1; j <= pe; j++) begin
                c[i+j] = c[i+j] ^ gf_mul(coef, gen[8*(pe-j) +: 8]);
            end
        end
        exp_q = {};
        for (int unsigned i = 0; i < k; i++) exp_q.push_back({(pe == 0) && (i == k-1), msg_q[i]});
        for (int unsigned j = 0; j < pe; j++) exp_q.push_back({(j == pe-1), c[k+j]});
    endtask

    // Called at posedge+1; returns at posedge+1 after max_out outputs accepted.
    task automatic run_codeword(input int bubble_in, input int bubble_out, input int stall_at,
                                input int max_out, input bit chg, input logic [255:0] chg_gen,
                                output int gaps);
        int in_idx, out_idx, cyc, stalls, k, total;
        bit do_chg;
        in_idx = 0; out_idx = 0; cyc = 0; stalls = 0; gaps = 0; do_chg = 0;
        k = msg_q.size();
        total = exp_q.size();
        while (out_idx < max_out && cyc < 2000) begin
            if (in_idx < k && int'($urandom_range(99)) >= bubble_in) begin
                in_valid = 1'b1;
                in_data  = msg_q[in_idx];
                in_last  = (in_idx == k-1);
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'b0;
            end
            if (out_idx == stall_at && out_valid && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = (int'($urandom_range(99)) >= bubble_out);
            end
            @(negedge clk);
            if (out_valid) begin
                check("out_data", {24'b0, out_data}, {24'b0, exp_q[out_idx][7:0]});
                check("out_last", {31'b0, out_last}, {31'b0, exp_q[out_idx][8]});
                check("busy_active", {31'b0, busy}, 32'd1);
                if (!out_ready) check("in_ready_stall", {31'b0, in_ready}, 32'd0);
                if (out_ready) out_idx++;
            end else if (out_idx > 0 && out_idx < total) begin
                gaps++;
            end
            if (total > k && out_idx >= k && out_idx < total - 1)
                check("in_ready_parity", {31'b0, in_ready}, 32'd0);
            if (in_valid && in_ready) begin
                in_idx++;
                if (chg && in_idx == 1) do_chg = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (do_chg) begin
                gen_poly_flat = chg_gen;
                do_chg = 1'b0;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("out_count", out_idx, max_out);
    endtask

    task automatic end_check();
        @(negedge clk);
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_out_valid", {31'b0, out_valid}, 32'd0);
        check("idle_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int gaps;
        int unsigned pc;
        int k;

        rst = 1'b1;
        reduction_matrix = make_matrix();
        parity_count = 6'd2;
        gen_poly_flat = gen_with(8'h02, 8'h03);
        in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd0);
        check("rst_out_data", {24'b0, out_data}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Single-symbol message
        msg_q = {8'h01};
        exp_q = {9'h001, 9'h003, 9'h102};
        run_codeword(0, 0, -1, 3, 1'b0, '0, gaps);
        check("contig_single", gaps, 0);
        end_check();

        // Two-symbol message, full throughput
        msg_q = {8'h01, 8'h00};
        exp_q = {9'h001, 9'h000, 9'h007, 9'h106};
        run_codeword(0, 0, -1, 4, 1'b0, '0, gaps);
        check("contig_two", gaps, 0);
        end_check();

        // Backpressure on the first parity symbol
        run_codeword(0, 0, 2, 4, 1'b0, '0, gaps);
        end_check();

        // P = 0 pass-through
        parity_count = 6'd0;
        gen_poly_flat = gen_with(8'h55, 8'hAA);
        msg_q = {8'h5A, 8'hA5};
        exp_q = {9'h05A, 9'h1A5};
        run_codeword(0, 0, -1, 2, 1'b0, '0, gaps);
        end_check();

        // Reset in the middle of the parity phase
        parity_count = 6'd2;
        gen_poly_flat = gen_with(8'h02, 8'h03);
        msg_q = {8'h01, 8'h00};
        exp_q = {9'h001, 9'h000, 9'h007, 9'h106};
        run_codeword(0, 0, -1, 2, 1'b0, '0, gaps);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_out_last", {31'b0, out_last}, 32'd0);
        check("midrst_out_data", {24'b0, out_data}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        msg_q = {8'h01};
        exp_q = {9'h001, 9'h003, 9'h102};
        run_codeword(0, 0, -1, 3, 1'b0, '0, gaps);
        end_check();

`ifdef RS_ENC_PARAM_LATCH_EN
        // Generator change after the first symbol must not affect this codeword
        msg_q = {8'h01, 8'h00};
        exp_q = {9'h001, 9'h000, 9'h007, 9'h106};
        run_codeword(0, 0, -1, 4, 1'b1, gen_with(8'h02, 8'h00), gaps);
        end_check();
`endif

        // Randomized codewords against the division model
        for (int t = 0; t < 40; t++) begin
            case (t)
                0: pc = 0;
                1: pc = 1;
                2: pc = 32;
                3: pc = 63;
                default: pc = $urandom_range(0, 40);
            endcase
            k = $urandom_range(1, 20);
            parity_count = 6'(pc);
            for (int i = 0; i < 8; i++) gen_poly_flat[32*i +: 32] = $urandom;
            msg_q = {};
            for (int i = 0; i < k; i++) msg_q.push_back(8'($urandom));
            build_expected(pc, gen_poly_flat);
            run_codeword($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 30),
                         exp_q.size(), 1'b0, '0, gaps);
            end_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
